// File: rtl/spi_pwm_pkg.sv
// Shared types and constants for the SPI-fed PWM loader.
// FSM state encoding and transaction geometry.
package spi_pwm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SEND,
        WAIT_RX,
        CS_HOLD
    } state_t;

    localparam int         NUM_CH     = 3;
    localparam int         NUM_BYTES  = 4;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

endpackage

// File: rtl/spi_pwm_loader_if.sv
// Byte-level link between the loader and the SPI master.
// master = loader side, slave = SPI master side.
interface spi_pwm_loader_if;

    logic [7:0] o_TX_Byte;
    logic       o_TX_DV;
    logic       i_TX_Ready;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_SPI_CS_n;

    modport master (
        output o_TX_Byte, o_TX_DV, o_SPI_CS_n,
        input  i_TX_Ready, i_RX_DV, i_RX_Byte
    );

    modport slave (
        input  o_TX_Byte, o_TX_DV, o_SPI_CS_n,
        output i_TX_Ready, i_RX_DV, i_RX_Byte
    );

endinterface

// File: rtl/spi_pwm_loader_pwm_channel.sv
// One PWM channel: active duty register plus compare
// against the shared free-running counter.
module pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic                 load,
    input  logic [PWM_WIDTH-1:0] duty_in,
    output logic                 pwm
);

    logic [PWM_WIDTH-1:0] active;

    // Latch new duty at the period boundary; register the compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load) active <= duty_in;
            pwm <= (cnt < active);
        end
    end

endmodule

// File: rtl/spi_pwm_loader.sv
// Polls an SPI slave for three duty bytes and drives three
// glitch-free PWM outputs, committing new duties at period wrap.
module spi_pwm_loader
    import spi_pwm_pkg::*;
#(
    parameter int         CLKS_PER_POLL = 10000,
    parameter int         PWM_WIDTH     = 8,
    parameter logic [7:0] CMD_BYTE      = 8'hA5,
    parameter int         CS_GUARD_CLKS = 2,
    parameter int         RX_TIMEOUT    = 64
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    spi_pwm_loader_if.master       bus,
    output logic                   o_pwm0,
    output logic                   o_pwm1,
    output logic                   o_pwm2,
    output logic                   o_err
);

    localparam int PW = $clog2(CLKS_PER_POLL + 1);
    localparam int GW = $clog2(CS_GUARD_CLKS + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    state_t state, state_n;

    logic [PW-1:0]        poll_cnt;
    logic [GW-1:0]        gcnt;
    logic [TW-1:0]        to_cnt;
    logic [1:0]           k;
    logic [PWM_WIDTH-1:0] shadow [NUM_CH];
    logic                 pending;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [NUM_CH-1:0]    pwm;

    logic [7:0] tx_byte, tx_byte_d;
    logic       tx_dv, tx_dv_d;
    logic       cs_n, cs_n_d;
    logic       err, err_d;
    logic       set_pending;

    logic poll_hit, guard_hit, send_go;
    logic rx_take, to_hit, last_byte, hold_done, commit;

    assign poll_hit  = (state == IDLE) &&
                       (poll_cnt == PW'(CLKS_PER_POLL - 1));
    assign guard_hit = (gcnt == GW'(CS_GUARD_CLKS - 1));
    assign send_go   = (state == SEND) && bus.i_TX_Ready;
    assign rx_take   = (state == WAIT_RX) && bus.i_RX_DV;
    assign to_hit    = (state == WAIT_RX) && !bus.i_RX_DV &&
                       (to_cnt == TW'(RX_TIMEOUT - 1));
    assign last_byte = (k == 2'(NUM_BYTES - 1));
    assign hold_done = (state == CS_HOLD) && guard_hit;
    assign commit    = pending && (pwm_cnt == '1);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_n;
    end

    // FSM next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (poll_hit) state_n = CS_SETUP;
            CS_SETUP: if (guard_hit) state_n = SEND;
            SEND:     if (send_go) state_n = WAIT_RX;
            WAIT_RX: begin
                if (rx_take)     state_n = last_byte ? CS_HOLD : SEND;
                else if (to_hit) state_n = IDLE;
            end
            CS_HOLD:  if (guard_hit) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered bus/status signals
    always_comb begin
        tx_dv_d     = send_go;
        tx_byte_d   = tx_byte;
        err_d       = to_hit;
        cs_n_d      = cs_n;
        set_pending = hold_done;
        if (send_go)
            tx_byte_d = (k == '0) ? CMD_BYTE : DUMMY_BYTE;
        if (poll_hit)
            cs_n_d = 1'b0;
        if (to_hit || hold_done)
            cs_n_d = 1'b1;
    end

    // Counters, byte capture, pending flag and registered outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            poll_cnt <= '0;
            gcnt     <= '0;
            to_cnt   <= '0;
            k        <= '0;
            pending  <= 1'b0;
            pwm_cnt  <= '0;
            tx_byte  <= '0;
            tx_dv    <= 1'b0;
            cs_n     <= 1'b1;
            err      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else begin
            tx_dv   <= tx_dv_d;
            tx_byte <= tx_byte_d;
            cs_n    <= cs_n_d;
            err     <= err_d;
            pwm_cnt <= pwm_cnt + 1'b1;

            poll_cnt <= (state == IDLE && !poll_hit) ?
                        poll_cnt + 1'b1 : '0;
            gcnt     <= ((state == CS_SETUP || state == CS_HOLD) &&
                         !guard_hit) ? gcnt + 1'b1 : '0;
            to_cnt   <= (state == WAIT_RX) ? to_cnt + 1'b1 : '0;

            if (poll_hit)
                k <= '0;
            else if (rx_take && !last_byte)
                k <= k + 1'b1;

            if (rx_take && k != '0)
                shadow[k - 2'd1] <= PWM_WIDTH'(bus.i_RX_Byte);

            // A fresh transaction invalidates an uncommitted older set
            // so a later abort can never commit a half-written mix.
            if (set_pending)
                pending <= 1'b1;
            else if (rx_take && k == 2'd1)
                pending <= 1'b0;
            else if (commit)
                pending <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
            .clk     (i_clk),
            .rst_n   (i_reset),
            .cnt     (pwm_cnt),
            .load    (commit),
            .duty_in (shadow[i]),
            .pwm     (pwm[i])
        );
    end

    assign bus.o_TX_Byte  = tx_byte;
    assign bus.o_TX_DV    = tx_dv;
    assign bus.o_SPI_CS_n = cs_n;
    assign o_err          = err;
    assign o_pwm0         = pwm[0];
    assign o_pwm1         = pwm[1];
    assign o_pwm2         = pwm[2];

endmodule

// File: tb/tb_spi_pwm_loader.sv
// Scoreboard bench for spi_pwm_loader: slave model, TX/err/CS
// monitor fed by expectation queues, PWM duty measurements.
module tb_spi_pwm_loader;

    localparam int P   = 1000;
    localparam int G   = 2;
    localparam int T   = 64;
    localparam int LAT = 12;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } tx_exp_t;

    logic clk;
    logic i_reset;
    logic o_pwm0, o_pwm1, o_pwm2, o_err;

    spi_pwm_loader_if bus ();

    spi_pwm_loader #(
        .CLKS_PER_POLL (P),
        .PWM_WIDTH     (8),
        .CMD_BYTE      (8'hA5),
        .CS_GUARD_CLKS (G),
        .RX_TIMEOUT    (T)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .bus     (bus),
        .o_pwm0  (o_pwm0),
        .o_pwm1  (o_pwm1),
        .o_pwm2  (o_pwm2),
        .o_err   (o_err)
    );

    int      cyc = 0;
    int      ntot = 0;
    int      npass = 0;
    int      rel_cyc = 0;
    tx_exp_t exp_tx[$];
    int      exp_cnt[$];
    int      err_exp = 0;
    int      tx_in_txn = 0;
    int      last_tx_cyc = 0;

    logic busy = 1'b0;
    logic force_low = 1'b0;
    logic loopback = 1'b1;
    int   drop_idx = -1;

    assign bus.i_TX_Ready = !busy && !force_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_txn(input int first_cyc, input int n);
        tx_exp_t e;
        e.b   = 8'hA5;
        e.cyc = first_cyc;
        exp_tx.push_back(e);
        for (int i = 1; i < n; i++) begin
            e.b   = 8'h00;
            e.cyc = -1;
            exp_tx.push_back(e);
        end
        exp_cnt.push_back(n);
    endtask

    task automatic wait_cs(input logic lvl, input int budget,
                           input string name);
        int n = 0;
        while (bus.o_SPI_CS_n !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus.o_SPI_CS_n === lvl), 1);
    endtask

    task automatic measure(input int e0, input int e1, input int e2,
                           input string name);
        int c0 = 0;
        int c1 = 0;
        int c2 = 0;
        repeat (256) begin
            @(negedge clk);
            c0 += int'(o_pwm0);
            c1 += int'(o_pwm1);
            c2 += int'(o_pwm2);
        end
        chk({name, "_pwm0_high"}, c0, e0);
        chk({name, "_pwm1_high"}, c1, e1);
        chk({name, "_pwm2_high"}, c2, e2);
    endtask

    // First rising pwm0 after commit must land on counter=0 of the
    // first wrap that follows the CS release edge.
    task automatic wait_commit(input int rise, input string name);
        int k = ((rise - rel_cyc) / 256 + 1) * 256;
        int n = 0;
        while (o_pwm0 !== 1'b1 && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_commit_cycle"}, cyc, rel_cyc + k + 1);
        chk({name, "_pwm1_aligned"}, int'(o_pwm1), 1);
        chk({name, "_pwm2_aligned"}, int'(o_pwm2), 1);
    endtask

    // Slave model: answers each TX byte after LAT clocks
    initial begin
        int s_idx;
        logic [7:0] txb;
        logic [7:0] resp [4];
        resp = '{8'hA5, 8'h40, 8'h80, 8'hFF};
        s_idx = 0;
        bus.i_RX_DV = 1'b0;
        bus.i_RX_Byte = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.o_SPI_CS_n) s_idx = 0;
            if (bus.o_TX_DV) begin
                txb  = bus.o_TX_Byte;
                busy = 1'b1;
                repeat (LAT) @(negedge clk);
                if (s_idx != drop_idx) begin
                    bus.i_RX_Byte = loopback ? txb : resp[s_idx % 4];
                    bus.i_RX_DV = 1'b1;
                    @(negedge clk);
                    bus.i_RX_DV = 1'b0;
                end
                busy = 1'b0;
                s_idx++;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents TX/err/CS events
    initial begin
        logic prev_dv = 1'b0;
        logic prev_err = 1'b0;
        logic prev_cs = 1'b1;
        tx_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_TX_DV === 1'b1) begin
                chk("tx_dv_width", int'(prev_dv), 0);
                chk("tx_expected", int'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", int'(bus.o_TX_Byte), int'(e.b));
                    if (e.cyc >= 0) chk("tx_cycle", cyc, e.cyc);
                end
                tx_in_txn++;
                last_tx_cyc = cyc;
            end
            if (o_err === 1'b1) begin
                chk("err_width", int'(prev_err), 0);
                chk("err_expected", int'(err_exp > 0), 1);
                if (err_exp > 0) begin
                    chk("err_latency", cyc - last_tx_cyc, T);
                    err_exp--;
                end
            end
            if (prev_cs === 1'b1 && bus.o_SPI_CS_n === 1'b0)
                tx_in_txn = 0;
            if (prev_cs === 1'b0 && bus.o_SPI_CS_n === 1'b1) begin
                chk("cs_release_expected", int'(exp_cnt.size() > 0), 1);
                if (exp_cnt.size() > 0)
                    chk("tx_per_txn", tx_in_txn, exp_cnt.pop_front());
            end
            prev_dv  = bus.o_TX_DV;
            prev_err = o_err;
            prev_cs  = bus.o_SPI_CS_n;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int rise;
        int n;
        i_reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_cs_n", int'(bus.o_SPI_CS_n), 1);
        chk("rst_tx_dv", int'(bus.o_TX_DV), 0);
        chk("rst_tx_byte", int'(bus.o_TX_Byte), 0);
        chk("rst_pwm", int'({o_pwm2, o_pwm1, o_pwm0}), 0);
        chk("rst_err", int'(o_err), 0);

        // Loopback transaction: all duties become zero
        i_reset = 1'b1;
        rel_cyc = cyc;
        push_txn(rel_cyc + P + G + 1, 4);
        wait_cs(1'b0, P + 10, "t1_cs_low");
        wait_cs(1'b1, 400, "t1_cs_high");
        repeat (300) @(negedge clk);
        measure(0, 0, 0, "loopback");

        // Slave returns 0x40/0x80/0xFF
        loopback = 1'b0;
        push_txn(-1, 4);
        wait_cs(1'b0, P + 10, "t2_cs_low");
        wait_cs(1'b1, 400, "t2_cs_high");
        rise = cyc;
        wait_commit(rise, "t2");
        measure(64, 128, 255, "normal");

        // RX suppressed for the third byte: timeout, duties retained
        drop_idx = 2;
        push_txn(-1, 3);
        err_exp = 1;
        wait_cs(1'b0, P + 10, "t3_cs_low");
        wait_cs(1'b1, 400, "t3_cs_high");
        drop_idx = -1;
        repeat (300) @(negedge clk);
        measure(64, 128, 255, "retain");

        // Ready held low for 20 clocks in SEND
        wait_cs(1'b0, P + 10, "t4_cs_low");
        force_low = 1'b1;
        repeat (G + 20) @(negedge clk);
        force_low = 1'b0;
        push_txn(cyc + 1, 4);
        wait_cs(1'b1, 400, "t4_cs_high");
        repeat (300) @(negedge clk);
        measure(64, 128, 255, "ready_low");

        // Reset during WAIT_RX of byte 2
        push_txn(-1, 3);
        wait_cs(1'b0, P + 10, "t5_cs_low");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_in_txn != 3 && n < 300);
        chk("t5_third_tx", tx_in_txn, 3);
        repeat (3) @(negedge clk);
        #2 i_reset = 1'b0;
        #1;
        chk("t5_cs_n", int'(bus.o_SPI_CS_n), 1);
        chk("t5_pwm", int'({o_pwm2, o_pwm1, o_pwm0}), 0);
        chk("t5_tx_dv", int'(bus.o_TX_DV), 0);
        repeat (4) @(negedge clk);
        i_reset = 1'b1;
        rel_cyc = cyc;
        push_txn(rel_cyc + P + G + 1, 4);
        measure(0, 0, 0, "post_reset");
        wait_cs(1'b0, P + 10, "t6_cs_low");
        wait_cs(1'b1, 400, "t6_cs_high");
        rise = cyc;
        wait_commit(rise, "t6");
        measure(64, 128, 255, "t6");

        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("cnt_queue_drained", exp_cnt.size(), 0);
        chk("err_drained", err_exp, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
